ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 8-bit-address / 32-bit-data SoC RAM between two requesters.
  - Port 0 (P0): instruction fetch, read-only.
  - Port 1 (P1): data, i.e. load/store/AMO traffic from the ram mux path.
- Sequences each access through a registered FSM that drives the RAM CE/RD/WR/ADDR/DATA lines.
- Returns read data with a valid pulse.
- Supports a lock so AMO read-modify-write pairs on P1 are not split by fetches.
- Sits between the core-side requesters and the RAM instance.

Parameters:
- AW, 8, RAM address width.
- DW, 32, RAM data width.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ_0  in  1  P0 request; held until oGNT_0.
- iADDR_0  in  AW  P0 read address.
- oGNT_0  out  1  P0 request accepted (one-cycle pulse).
- oRVALID_0  out  1  P0 read data valid (one-cycle pulse).
- oRDATA_0  out  DW  P0 read data.
- iREQ_1  in  1  P1 request; held until oGNT_1.
- iWE_1  in  1  P1 write (1) / read (0).
- iLOCK_1  in  1  P1 lock request; sampled with iREQ_1.
- iADDR_1  in  AW  P1 address.
- iWDATA_1  in  DW  P1 write data.
- oGNT_1  out  1  P1 request accepted (pulse).
- oRVALID_1  out  1  P1 read data valid (pulse).
- oRDATA_1  out  DW  P1 read data.
- oRAM_CE, oRAM_RD, oRAM_WR  out  1 each  RAM strobes.
- oRAM_ADDR  out  AW  RAM address.
- oRAM_DATA_WR  out  DW  RAM write data.
- iRAM_DATA_RD  in  DW  RAM read data; valid the cycle after CE&RD (1-cycle synchronous read).
- oLOCKED  out  1  lock held by P1.

Behaviour:
- Reset (async, iRST_N=0):
  - State IDLE.
  - All outputs 0; oRDATA_* = 0.
  - Lock cleared; RR pointer = P1.
- Reset mid-access aborts the access: no RVALID, RAM strobes drop immediately.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrate among active requests.
  - Latch the winner's addr/we/wdata/lock into registers.
  - Pulse the winner's oGNT in the same cycle.
  - Go to ACCESS.
  - No request: stay in IDLE, all strobes 0.
- Arbitration:
  - Fixed priority, P1 > P0.
  - While oLOCKED=1, only P1 may be granted; iREQ_0 waits.
- ACCESS:
  - Drive oRAM_CE=1, oRAM_ADDR/oRAM_DATA_WR from registers.
  - Drive oRAM_RD=~we and oRAM_WR=we.
  - Write: return to IDLE.
  - Read: go to RESP.
- RESP:
  - Strobes 0.
  - Register iRAM_DATA_RD into the winner's oRDATA.
  - Pulse the winner's oRVALID in the next cycle, which overlaps IDLE.
  - Go to IDLE.
- oRDATA holds its last value until the next read to that port completes.
- Latency:
  - Read: GNT at cycle T, RAM access at T+1, RVALID at T+3.
  - Write: GNT at T, RAM write at T+1.
  - Peak throughput: one read per 3 cycles, one write per 2 cycles.
- Lock:
  - oLOCKED is set when a P1 request with iLOCK_1=1 is granted.
  - It clears when a P1 request with iLOCK_1=0 is granted; that request is still served under the lock.
  - Lock persists across idle cycles indefinitely.
- Simultaneous events:
  - Both requests in IDLE: P1 wins.
  - RVALID of the previous read and GNT of a new request may coincide.
  - A request that arrives during ACCESS/RESP is not granted until IDLE.
- oRAM_ADDR and oRAM_DATA_WR are 0 outside ACCESS.
- A read on P0 with iWE ignored: P0 never writes.

Optional Feature:
- Macro RAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration.
  - 1-bit pointer names the port that last won; on contention the other port wins.
  - Pointer updates on every grant.
  - Lock still overrides.
- Undefined: fixed priority P1 > P0; pointer logic absent.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and port ids (PORT_FETCH=1'b0, PORT_DATA=1'b1).
- One sub-module: ram_arb_pick, a combinational winner select.
  - Inputs: req0, req1, locked, rr_ptr.
  - Outputs: gnt0, gnt1.
  - Contains the RAM_ARB_RR_EN conditional.

Test Plan:
- Reset/read: reset mid-ACCESS, then P0 read of addr 0x10 (RAM holds 0xDEADBEEF).
  - No RVALID from the aborted access.
  - oGNT_0 at T, oRAM_CE&oRAM_RD with ADDR=0x10 at T+1.
  - oRVALID_0=1 with oRDATA_0=0xDEADBEEF at T+3.
- P1 write: addr 0x20, data 0x12345678.
  - oRAM_WR=1, oRAM_ADDR=0x20, oRAM_DATA_WR=0x12345678 at T+1.
  - Next request grantable at T+2.
- Contention: P0 and P1 request in the same cycle.
  - Fixed mode: P1 granted first, P0 granted at T+3.
  - RAM_ARB_RR_EN mode: grants alternate P1, P0, P1 across 3 back-to-back contention rounds.
- Lock: P1 read 0x30 with iLOCK_1=1, P0 requests continuously, then P1 write 0x30 with iLOCK_1=0.
  - P0 not granted until after the unlocking write's GNT.
  - oLOCKED high for exactly that window.
- Back-to-back reads: P0 reads 0x00, 0x01, 0x02 (RAM holds 0xA, 0xB, 0xC).
  - oRVALID_0 pulses at 3-cycle spacing with data 0xA, 0xB, 0xC in order.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM states and requester ids.
// Optional round-robin arbitration is selected with the RAM_ARB_RR_EN macro.
package ram_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  function automatic logic winnerPort(input logic gnt1);
    return gnt1 ? PORT_DATA : PORT_FETCH;
  endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational winner select for the RAM arbiter; a held lock admits only P1.
// RAM_ARB_RR_EN selects round-robin on contention, otherwise P1 has fixed priority.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic locked,
  input  logic rr_ptr,
  output logic gnt0,
  output logic gnt1
);

`ifndef RAM_ARB_RR_EN
  logic unusedPtr;
  assign unusedPtr = rr_ptr;
`endif

  // Winner select; with RR the port that did not win last time takes a contended slot.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (locked) begin
      gnt0 = 1'b0;
      gnt1 = req1;
    end else begin
`ifdef RAM_ARB_RR_EN
      if (req0 && req1) begin
        gnt0 = (rr_ptr == PORT_DATA);
        gnt1 = (rr_ptr == PORT_FETCH);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`else
      gnt0 = req0 & ~req1;
      gnt1 = req1;
`endif
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port SoC RAM between instruction fetch (P0) and data (P1).
// Optional round-robin arbitration via RAM_ARB_RR_EN; default is fixed priority P1 > P0.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iREQ_0,
  input  logic [AW-1:0] iADDR_0,
  output logic          oGNT_0,
  output logic          oRVALID_0,
  output logic [DW-1:0] oRDATA_0,
  input  logic          iREQ_1,
  input  logic          iWE_1,
  input  logic          iLOCK_1,
  input  logic [AW-1:0] iADDR_1,
  input  logic [DW-1:0] iWDATA_1,
  output logic          oGNT_1,
  output logic          oRVALID_1,
  output logic [DW-1:0] oRDATA_1,
  output logic          oRAM_CE,
  output logic          oRAM_RD,
  output logic          oRAM_WR,
  output logic [AW-1:0] oRAM_ADDR,
  output logic [DW-1:0] oRAM_DATA_WR,
  input  logic [DW-1:0] iRAM_DATA_RD,
  output logic          oLOCKED
);

  logic [1:0]    stateR;
  logic          portR;
  logic          lockedR;
  logic          rrPtrS;
  logic          pick0S;
  logic          pick1S;
  logic          gnt0S;
  logic          gnt1S;
  logic          anyGntS;
  logic          reqWeS;
  logic [AW-1:0] reqAddrS;
  logic          ramCeR;
  logic          ramRdR;
  logic          ramWrR;
  logic [AW-1:0] ramAddrR;
  logic [DW-1:0] ramDataR;
  logic          rvalid0R;
  logic          rvalid1R;
  logic [DW-1:0] rdata0R;
  logic [DW-1:0] rdata1R;

  ram_arb_pick uPick (
    .req0   (iREQ_0),
    .req1   (iREQ_1),
    .locked (lockedR),
    .rr_ptr (rrPtrS),
    .gnt0   (pick0S),
    .gnt1   (pick1S)
  );

  assign gnt0S   = (stateR == IDLE) & pick0S;
  assign gnt1S   = (stateR == IDLE) & pick1S;
  assign anyGntS = gnt0S | gnt1S;

  // Winner's request fields; P0 is fetch-only so its write enable is forced low.
  always_comb begin
    reqWeS   = 1'b0;
    reqAddrS = {AW{1'b0}};
    if (gnt1S) begin
      reqWeS   = iWE_1;
      reqAddrS = iADDR_1;
    end else begin
      reqWeS   = 1'b0;
      reqAddrS = iADDR_0;
    end
  end

  // Access sequencer: writes return to IDLE after ACCESS, reads pass through RESP.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateR <= IDLE;
    end else begin
      case (stateR)
        IDLE:    stateR <= anyGntS ? ACCESS : IDLE;
        ACCESS:  stateR <= ramWrR ? IDLE : RESP;
        RESP:    stateR <= IDLE;
        default: stateR <= IDLE;
      endcase
    end
  end

  // RAM strobes are loaded at grant, so they are live exactly during ACCESS.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ramCeR   <= 1'b0;
      ramRdR   <= 1'b0;
      ramWrR   <= 1'b0;
      ramAddrR <= {AW{1'b0}};
      ramDataR <= {DW{1'b0}};
    end else if (anyGntS) begin
      ramCeR   <= 1'b1;
      ramRdR   <= ~reqWeS;
      ramWrR   <= reqWeS;
      ramAddrR <= reqAddrS;
      ramDataR <= gnt1S ? iWDATA_1 : {DW{1'b0}};
    end else begin
      ramCeR   <= 1'b0;
      ramRdR   <= 1'b0;
      ramWrR   <= 1'b0;
      ramAddrR <= {AW{1'b0}};
      ramDataR <= {DW{1'b0}};
    end
  end

  // Owner of the in-flight access and the P1 lock, both updated on grant.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      portR   <= PORT_FETCH;
      lockedR <= 1'b0;
    end else begin
      if (anyGntS) begin
        portR <= winnerPort(gnt1S);
      end
      if (gnt1S) begin
        lockedR <= iLOCK_1;
      end
    end
  end

  // Read response: RAM data is valid in RESP and lands with a one-cycle valid pulse.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rvalid0R <= 1'b0;
      rvalid1R <= 1'b0;
      rdata0R  <= {DW{1'b0}};
      rdata1R  <= {DW{1'b0}};
    end else begin
      rvalid0R <= 1'b0;
      rvalid1R <= 1'b0;
      if (stateR == RESP) begin
        if (portR == PORT_DATA) begin
          rvalid1R <= 1'b1;
          rdata1R  <= iRAM_DATA_RD;
        end else begin
          rvalid0R <= 1'b1;
          rdata0R  <= iRAM_DATA_RD;
        end
      end
    end
  end

`ifdef RAM_ARB_RR_EN
  logic rrPtrR;

  // Last-winner pointer; reset points at P1 so P0 wins the first contention.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rrPtrR <= PORT_DATA;
    end else if (anyGntS) begin
      rrPtrR <= winnerPort(gnt1S);
    end else begin
      rrPtrR <= rrPtrR;
    end
  end

  assign rrPtrS = rrPtrR;
`else
  assign rrPtrS = PORT_DATA;
`endif

  assign oGNT_0       = gnt0S;
  assign oGNT_1       = gnt1S;
  assign oRVALID_0    = rvalid0R;
  assign oRVALID_1    = rvalid1R;
  assign oRDATA_0     = rdata0R;
  assign oRDATA_1     = rdata1R;
  assign oRAM_CE      = ramCeR;
  assign oRAM_RD      = ramRdR;
  assign oRAM_WR      = ramWrR;
  assign oRAM_ADDR    = ramAddrR;
  assign oRAM_DATA_WR = ramDataR;
  assign oLOCKED      = lockedR;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 1-cycle synchronous RAM model.
// Contention expectations follow RAM_ARB_RR_EN when it is defined.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iREQ_0;
  logic [AW-1:0] iADDR_0;
  logic          oGNT_0;
  logic          oRVALID_0;
  logic [DW-1:0] oRDATA_0;
  logic          iREQ_1;
  logic          iWE_1;
  logic          iLOCK_1;
  logic [AW-1:0] iADDR_1;
  logic [DW-1:0] iWDATA_1;
  logic          oGNT_1;
  logic          oRVALID_1;
  logic [DW-1:0] oRDATA_1;
  logic          oRAM_CE;
  logic          oRAM_RD;
  logic          oRAM_WR;
  logic [AW-1:0] oRAM_ADDR;
  logic [DW-1:0] oRAM_DATA_WR;
  logic [DW-1:0] iRAM_DATA_RD;
  logic          oLOCKED;

  logic [DW-1:0] mem [0:255];
  logic          preloaded = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iREQ_0       (iREQ_0),
    .iADDR_0      (iADDR_0),
    .oGNT_0       (oGNT_0),
    .oRVALID_0    (oRVALID_0),
    .oRDATA_0     (oRDATA_0),
    .iREQ_1       (iREQ_1),
    .iWE_1        (iWE_1),
    .iLOCK_1      (iLOCK_1),
    .iADDR_1      (iADDR_1),
    .iWDATA_1     (iWDATA_1),
    .oGNT_1       (oGNT_1),
    .oRVALID_1    (oRVALID_1),
    .oRDATA_1     (oRDATA_1),
    .oRAM_CE      (oRAM_CE),
    .oRAM_RD      (oRAM_RD),
    .oRAM_WR      (oRAM_WR),
    .oRAM_ADDR    (oRAM_ADDR),
    .oRAM_DATA_WR (oRAM_DATA_WR),
    .iRAM_DATA_RD (iRAM_DATA_RD),
    .oLOCKED      (oLOCKED)
  );

  always #5 iCLK = ~iCLK;

  // RAM model: contents preloaded on the first edge, then synchronous read/write.
  always @(posedge iCLK) begin
    if (!preloaded) begin
      for (int a = 0; a < 256; a++) mem[a] <= 32'h0;
      mem[8'h00] <= 32'h0000_000A;
      mem[8'h01] <= 32'h0000_000B;
      mem[8'h02] <= 32'h0000_000C;
      mem[8'h10] <= 32'hDEAD_BEEF;
      mem[8'h30] <= 32'hCAFE_0030;
      preloaded  <= 1'b1;
      iRAM_DATA_RD <= 32'h0;
    end else begin
      if (oRAM_CE && oRAM_WR) mem[oRAM_ADDR] <= oRAM_DATA_WR;
      if (oRAM_CE && oRAM_RD) iRAM_DATA_RD <= mem[oRAM_ADDR];
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic atNeg;
    @(negedge iCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          nRounds;
  logic [2:0]  expWin;
  logic        keepP1;
  logic [31:0] bbExp [3];

  initial begin
    iRST_N = 1'b0; iREQ_0 = 1'b0; iADDR_0 = 8'h00; iREQ_1 = 1'b0; iWE_1 = 1'b0;
    iLOCK_1 = 1'b0; iADDR_1 = 8'h00; iWDATA_1 = 32'h0;
    bbExp[0] = 32'h0000_000A; bbExp[1] = 32'h0000_000B; bbExp[2] = 32'h0000_000C;
    tick; tick;
    atNeg;
    checkEq("reset gnt", {oGNT_0, oGNT_1}, 32'h0);
    checkEq("reset rvalid", {oRVALID_0, oRVALID_1}, 32'h0);
    checkEq("reset rdata0", oRDATA_0, 32'h0);
    checkEq("reset rdata1", oRDATA_1, 32'h0);
    checkEq("reset strobes", {oRAM_CE, oRAM_RD, oRAM_WR}, 32'h0);
    checkEq("reset addr", oRAM_ADDR, 32'h0);
    checkEq("reset locked", oLOCKED, 32'h0);
    tick; iRST_N = 1'b1;

    // Access aborted by reset while in ACCESS
    iREQ_0 = 1'b1; iADDR_0 = 8'h10;
    atNeg; checkEq("abort gnt0", oGNT_0, 32'h1);
    tick; iREQ_0 = 1'b0;
    atNeg; checkEq("abort ce", oRAM_CE, 32'h1);
    #2; iRST_N = 1'b0;
    #1; checkEq("abort strobes drop", {oRAM_CE, oRAM_RD}, 32'h0);
    tick; iRST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      atNeg; checkEq($sformatf("abort no rvalid c%0d", k), oRVALID_0, 32'h0);
      tick;
    end

    // P0 read of 0x10
    iREQ_0 = 1'b1; iADDR_0 = 8'h10;
    atNeg; checkEq("rd gnt0 T", oGNT_0, 32'h1); checkEq("rd gnt1 T", oGNT_1, 32'h0);
    tick; iREQ_0 = 1'b0;
    atNeg; checkEq("rd strobes T+1", {oRAM_CE, oRAM_RD, oRAM_WR}, 32'h6);
    checkEq("rd addr T+1", oRAM_ADDR, 32'h10);
    tick; atNeg;
    checkEq("rd strobes T+2", {oRAM_CE, oRAM_RD, oRAM_WR}, 32'h0);
    checkEq("rd addr T+2", oRAM_ADDR, 32'h0);
    checkEq("rd no rvalid T+2", oRVALID_0, 32'h0);
    tick; atNeg;
    checkEq("rd rvalid0 T+3", oRVALID_0, 32'h1);
    checkEq("rd rdata0 T+3", oRDATA_0, 32'hDEAD_BEEF);
    checkEq("rd rvalid1 T+3", oRVALID_1, 32'h0);
    tick; atNeg;
    checkEq("rd rvalid pulse", oRVALID_0, 32'h0);
    checkEq("rd rdata hold", oRDATA_0, 32'hDEAD_BEEF);
    tick;

    // Contention: P0 reads 0x00, P1 reads 0x01
`ifdef RAM_ARB_RR_EN
    nRounds = 3; expWin = 3'b101; keepP1 = 1'b1;
`else
    nRounds = 2; expWin = 3'b001; keepP1 = 1'b0;
`endif
    iREQ_0 = 1'b1; iADDR_0 = 8'h00; iREQ_1 = 1'b1; iWE_1 = 1'b0; iADDR_1 = 8'h01;
    for (int r = 0; r < nRounds; r++) begin
      atNeg;
      checkEq($sformatf("cont r%0d gnt1", r), oGNT_1, {31'h0, expWin[r]});
      checkEq($sformatf("cont r%0d gnt0", r), oGNT_0, {31'h0, ~expWin[r]});
      if (r > 0) begin
        checkEq($sformatf("cont r%0d prev rvalid", r),
                expWin[r-1] ? oRVALID_1 : oRVALID_0, 32'h1);
        checkEq($sformatf("cont r%0d prev rdata", r),
                expWin[r-1] ? oRDATA_1 : oRDATA_0, expWin[r-1] ? 32'hB : 32'hA);
      end
      tick;
      if (!keepP1) iREQ_1 = 1'b0;
      if (r == nRounds - 1) begin iREQ_0 = 1'b0; iREQ_1 = 1'b0; end
      atNeg; checkEq($sformatf("cont r%0d access no gnt", r), {oGNT_0, oGNT_1}, 32'h0);
      tick;
      atNeg; checkEq($sformatf("cont r%0d resp no gnt", r), {oGNT_0, oGNT_1}, 32'h0);
      tick;
    end
    atNeg;
    checkEq("cont last rvalid", expWin[nRounds-1] ? oRVALID_1 : oRVALID_0, 32'h1);
    checkEq("cont last rdata", expWin[nRounds-1] ? oRDATA_1 : oRDATA_0,
            expWin[nRounds-1] ? 32'hB : 32'hA);
    tick;

    // P1 write 0x20, then read it back on P0 at T+2
    iREQ_1 = 1'b1; iWE_1 = 1'b1; iADDR_1 = 8'h20; iWDATA_1 = 32'h1234_5678;
    atNeg; checkEq("wr gnt1 T", oGNT_1, 32'h1); checkEq("wr gnt0 T", oGNT_0, 32'h0);
    tick; iREQ_1 = 1'b0; iWE_1 = 1'b0;
    atNeg;
    checkEq("wr strobes T+1", {oRAM_CE, oRAM_RD, oRAM_WR}, 32'h5);
    checkEq("wr addr T+1", oRAM_ADDR, 32'h20);
    checkEq("wr data T+1", oRAM_DATA_WR, 32'h1234_5678);
    tick; iREQ_0 = 1'b1; iADDR_0 = 8'h20;
    atNeg;
    checkEq("wr next gnt T+2", oGNT_0, 32'h1);
    checkEq("wr data zero T+2", oRAM_DATA_WR, 32'h0);
    tick; iREQ_0 = 1'b0; tick; tick;
    atNeg;
    checkEq("wr readback rvalid", oRVALID_0, 32'h1);
    checkEq("wr readback data", oRDATA_0, 32'h1234_5678);
    tick;

    // Lock: P1 locked read of 0x30 while P0 keeps requesting
    iREQ_1 = 1'b1; iWE_1 = 1'b0; iLOCK_1 = 1'b1; iADDR_1 = 8'h30;
    iREQ_0 = 1'b1; iADDR_0 = 8'h05;
    atNeg;
    checkEq("lock gnt1", oGNT_1, 32'h1); checkEq("lock gnt0", oGNT_0, 32'h0);
    checkEq("lock not yet", oLOCKED, 32'h0);
    tick; iREQ_1 = 1'b0; iLOCK_1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      atNeg;
      checkEq($sformatf("lock p0 held c%0d", k), oGNT_0, 32'h1 & 32'h0);
      checkEq($sformatf("lock held c%0d", k), oLOCKED, 32'h1);
      tick;
    end
    checkEq("lock read data", oRDATA_1, 32'hCAFE_0030);
    iREQ_1 = 1'b1; iWE_1 = 1'b1; iLOCK_1 = 1'b0; iWDATA_1 = 32'h55AA_55AA;
    atNeg;
    checkEq("unlock gnt1", oGNT_1, 32'h1); checkEq("unlock gnt0", oGNT_0, 32'h0);
    checkEq("unlock still locked", oLOCKED, 32'h1);
    tick; iREQ_1 = 1'b0; iWE_1 = 1'b0;
    atNeg;
    checkEq("unlock cleared", oLOCKED, 32'h0);
    checkEq("unlock access no gnt0", oGNT_0, 32'h0);
    checkEq("unlock write data", oRAM_DATA_WR, 32'h55AA_55AA);
    tick;
    atNeg; checkEq("unlock p0 gnt", oGNT_0, 32'h1);
    tick; iREQ_0 = 1'b0; tick; tick;
    atNeg; checkEq("unlock p0 rvalid", oRVALID_0, 32'h1);
    tick;

    // Back-to-back P0 reads of 0x00..0x02
    iREQ_0 = 1'b1; iADDR_0 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      atNeg;
      checkEq($sformatf("b2b gnt%0d", i), oGNT_0, 32'h1);
      if (i > 0) begin
        checkEq($sformatf("b2b rvalid%0d", i - 1), oRVALID_0, 32'h1);
        checkEq($sformatf("b2b rdata%0d", i - 1), oRDATA_0, bbExp[i-1]);
      end
      tick;
      iADDR_0 = 8'(i + 1);
      if (i == 2) iREQ_0 = 1'b0;
      atNeg;
      checkEq($sformatf("b2b access addr%0d", i), oRAM_ADDR, i);
      checkEq($sformatf("b2b access no rvalid%0d", i), oRVALID_0, 32'h0);
      tick;
      atNeg; checkEq($sformatf("b2b resp no gnt%0d", i), oGNT_0, 32'h0);
      tick;
    end
    atNeg;
    checkEq("b2b rvalid2", oRVALID_0, 32'h1);
    checkEq("b2b rdata2", oRDATA_0, bbExp[2]);
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
